// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Sample-to-bit mapping follows the serializer's byte-swapped order.
package sipo_pkg;

  localparam int WORD_W    = 16;
  localparam int FRAME_LEN = 16;

  localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  // 0..7 -> 7..0, 8..15 -> 15..8
  function automatic logic [3:0] bit_index(
    input logic [3:0] cnt
  );
    return {cnt[3], ~cnt[2:0]};
  endfunction

endpackage

// File: rtl/sipo_receiver_fifo.sv
// Synchronous first-word-fall-through FIFO.
// A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      wr_d;
  logic [AW:0]      rd_q;
  logic [AW:0]      rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sipo_receiver.sv
// Serial-to-parallel receiver: frame hunt, word reassembly,
// error/overflow pulses and a FWFT output FIFO.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        latch,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        synced,
  output logic        frame_err,
  output logic        overflow
);

  state_e              state_q;
  state_e              state_d;
  logic [3:0]          cnt_q;
  logic [3:0]          cnt_d;
  logic [WORD_W-1:0]   sh_q;
  logic [WORD_W-1:0]   sh_d;
  logic                ferr_q;
  logic                ferr_d;
  logic                ovf_q;
  logic                ovf_d;

  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W-1:0]   head;
  logic                full;
  logic                empty;

  logic hunt;
  logic last;
  logic rx_long;
  logic rx_bit;
  logic rx_done;
  logic rx_short;

  assign hunt     = (state_q == HUNT);
  assign last     = (cnt_q == LAST_CNT);
  assign rx_long  = !hunt && latch && last;
  assign rx_bit   = !hunt && latch && !last;
  assign rx_done  = !hunt && !latch && last;
  assign rx_short = !hunt && !latch && !last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    push_word = sh_q;
    unique case (1'b1)
      hunt: begin
        if (!latch) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      rx_long: begin
        ferr_d  = 1'b1;
        cnt_d   = '0;
        sh_d    = '0;
        state_d = HUNT;
      end
      rx_bit: begin
        sh_d[bit_index(cnt_q)] = sin;
        cnt_d = cnt_q + 1'b1;
      end
      rx_done: begin
        push_word[bit_index(cnt_q)] = sin;
        push  = 1'b1;
        cnt_d = '0;
      end
      rx_short: begin
        ferr_d = 1'b1;
        cnt_d  = '0;
        sh_d   = '0;
      end
      default: ;
    endcase
  end

  // A full FIFO still takes the word if the head leaves this cycle.
  assign ovf_d = push && full && !word_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (word_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign word_valid = !empty;
  assign word_data  = word_valid ? head : '0;
  assign synced     = (state_q == RECV);
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule
